adsr_envelope: RTL and testbench
================================

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have parameter width_p, 12: sample width, signed two's complement.
REQ-002 SHALL have parameter env_width_p, 8: envelope level width, unsigned; max level L = 2^env_width_p - 1.
REQ-003 SHALL have parameter attack_step_p, 4: level increment per accepted sample in ATTACK; legal range >= 1.
REQ-004 SHALL have parameter decay_step_p, 1: level decrement per accepted sample in DECAY; legal range >= 1.
REQ-005 SHALL have parameter sustain_level_p, 192: SUSTAIN level; legal range 0..L.
REQ-006 SHALL have parameter release_step_p, 2: level decrement per accepted sample in RELEASE; legal range >= 1.
REQ-007 SHALL have the following ports: clk_i  in  1  sole clock, rising edge.
REQ-008 reset_i  in  1  reset, synchronous and active-high.
REQ-009 gate_i  in  1  note held (1) or released (0).
REQ-010 data_i  in  width_p  signed sample from the upstream oscillator.
REQ-011 valid_i  in  1  data_i valid.
REQ-012 ready_o  out  1  block accepts data_i this cycle.
REQ-013 data_o  out  width_p  signed enveloped sample.
REQ-014 valid_o  out  1  data_o valid.
REQ-015 ready_i  in  1  downstream accepts data_o.
REQ-016 state_o  out  3  envelope state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-017 level_o  out  env_width_p  current envelope level.

Function
REQ-018 Accept: valid_i && ready_o; ready_o SHALL be ~valid_o | ready_i, i.e. a single output register with pass-through backpressure.
REQ-019 On accept, data_o SHALL load (data_i * {1'b0,level}) >>> env_width_p, arithmetic shift (floor), truncated to width_p bits; valid_o SHALL be set; latency is 1 cycle.
REQ-020 The multiply SHALL use the level held before that cycle's step.
REQ-021 With valid_o high and ready_i low, data_o and valid_o SHALL hold; no accept and no envelope step SHALL occur.
REQ-022 With valid_o high, ready_i high and no accept, valid_o SHALL clear next cycle.
REQ-023 Level and state SHALL update only on accept cycles; gate_i SHALL be sampled only on accept cycles.
REQ-024 IDLE: level 0; gate_i=1 SHALL go to ATTACK with no step on the same accept.
REQ-025 ATTACK: level += attack_step_p; a result >= L SHALL saturate to L and go to DECAY.
REQ-026 DECAY: level -= decay_step_p; a result <= sustain_level_p, including underflow, SHALL clamp to sustain_level_p and go to SUSTAIN.
REQ-027 SUSTAIN: level SHALL hold.
REQ-028 gate_i=0 on an accept in ATTACK, DECAY or SUSTAIN SHALL go to RELEASE with no step; gate_i=0 takes priority over the normal step.
REQ-029 RELEASE: level -= release_step_p; a result <= 0 SHALL clamp to 0 and go to IDLE.
REQ-030 gate_i=1 on an accept in RELEASE SHALL go to ATTACK from the current level (retrigger, no reset to 0).
REQ-031 sustain_level_p = L SHALL make DECAY exit to SUSTAIN on its first accept.
REQ-032 Arithmetic SHALL be computed at env_width_p+2 bits so that no wrap-around occurs before clamping.

Reset
REQ-033 Reset SHALL force state IDLE, level 0, data_o 0 and valid_o 0; ready_o is then 1.
REQ-034 Reset mid-envelope or mid-stall SHALL discard the held sample and the envelope state, with no output on the following cycle.

Structure
REQ-035 Package adsr_pkg SHALL hold the state enum typedef and the 3-bit encodings.
REQ-036 Sub-module adsr_scale SHALL hold the combinational signed multiply/shift/truncate; state machine and output register SHALL remain in adsr_envelope.

Verification
REQ-037 Reset then gate_i=1, valid_i=1, ready_i=1 held -> level 4,8,...,252, then 255 on accept 65 with state DECAY.
REQ-038 Continue -> 63 accepts of DECAY reach level 192 with state SUSTAIN; level holds over 100 further accepts.
REQ-039 Drop gate_i in SUSTAIN -> RELEASE; 96 accepts reach level 0 with state IDLE; data_o = 0 thereafter.
REQ-040 level 255 with data_i=2047 -> data_o=2039; data_i=-2048 -> data_o=-2040, one cycle after accept.
REQ-041 ready_i=0 for 5 cycles with valid_o=1 -> data_o stable, ready_o=0, level unchanged; ready_i=1 -> next accept proceeds.
REQ-042 Drop gate_i at level 100 in ATTACK, raise it at level 60 in RELEASE -> ATTACK resumes from 60 (64, 68, ...); reset_i asserted mid-RELEASE -> IDLE, level 0, valid_o 0 next cycle.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types for the ADSR envelope: state encodings visible on state_o.
package adsr_pkg;

  typedef enum logic [2:0] {
    ADSR_IDLE    = 3'd0,
    ADSR_ATTACK  = 3'd1,
    ADSR_DECAY   = 3'd2,
    ADSR_SUSTAIN = 3'd3,
    ADSR_RELEASE = 3'd4
  } adsr_state_e;

endpackage : adsr_pkg

// File: rtl/adsr_scale.sv
// Combinational gain stage: signed sample times unsigned level, floor-shifted
// back down by the level width and truncated to the sample width.
module adsr_scale #(
  parameter int width_p     = 12,
  parameter int env_width_p = 8
) (
  input  logic signed [width_p-1:0]     sample,
  input  logic        [env_width_p-1:0] level,
  output logic signed [width_p-1:0]     scaled
);

  logic signed [width_p+env_width_p:0] product;
  logic                                unused_bits;

  // Zero-extending the level keeps it non-negative inside the signed multiply.
  assign product     = sample * $signed({1'b0, level});
  assign scaled      = product[env_width_p +: width_p];
  assign unused_bits = ^{product[env_width_p-1:0], product[width_p+env_width_p]};

endmodule : adsr_scale

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope applied to a sample stream, with one output register
// and pass-through backpressure; the envelope advances once per accepted sample.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int width_p         = 12,
  parameter int env_width_p     = 8,
  parameter int attack_step_p   = 4,
  parameter int decay_step_p    = 1,
  parameter int sustain_level_p = 192,
  parameter int release_step_p  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      gate_i,
  input  logic signed [width_p-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic signed [width_p-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [2:0]                state_o,
  output logic [env_width_p-1:0]    level_o
);

  // Handshake: a beat transfers on a cycle where valid and ready are both high;
  // valid/data hold while the consumer stalls, and ready is ~valid_o | ready_i.

  typedef logic signed [env_width_p+1:0] wide_t;

  localparam wide_t max_w     = wide_t'((1 << env_width_p) - 1);
  localparam wide_t attack_w  = wide_t'(attack_step_p);
  localparam wide_t decay_w   = wide_t'(decay_step_p);
  localparam wide_t sustain_w = wide_t'(sustain_level_p);
  localparam wide_t release_w = wide_t'(release_step_p);
  localparam logic [env_width_p-1:0] sustain_lvl = env_width_p'(sustain_level_p);

  adsr_state_e                   state_q;
  logic        [env_width_p-1:0] level_q;
  logic signed [width_p-1:0]     data_q;
  logic                          valid_q;
  logic signed [width_p-1:0]     scaled;
  logic                          accept;
  wide_t                         level_w;
  wide_t                         attack_sum;
  wide_t                         decay_diff;
  wide_t                         release_diff;

  adsr_scale #(
    .width_p    (width_p),
    .env_width_p(env_width_p)
  ) u_scale (
    .sample(data_i),
    .level (level_q),
    .scaled(scaled)
  );

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  // Two guard bits so overshoot and underflow are seen before clamping.
  assign level_w      = {2'b00, level_q};
  assign attack_sum   = level_w + attack_w;
  assign decay_diff   = level_w - decay_w;
  assign release_diff = level_w - release_w;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ADSR_IDLE;
      level_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= scaled;
      valid_q <= 1'b1;
      case (state_q)
        ADSR_IDLE: begin
          level_q <= '0;
          if (gate_i) state_q <= ADSR_ATTACK;
        end
        ADSR_ATTACK: begin
          if (!gate_i) begin
            state_q <= ADSR_RELEASE;
          end else if (attack_sum >= max_w) begin
            level_q <= '1;
            state_q <= ADSR_DECAY;
          end else begin
            level_q <= attack_sum[env_width_p-1:0];
          end
        end
        ADSR_DECAY: begin
          if (!gate_i) begin
            state_q <= ADSR_RELEASE;
          end else if (decay_diff <= sustain_w) begin
            level_q <= sustain_lvl;
            state_q <= ADSR_SUSTAIN;
          end else begin
            level_q <= decay_diff[env_width_p-1:0];
          end
        end
        ADSR_SUSTAIN: begin
          if (!gate_i) state_q <= ADSR_RELEASE;
        end
        ADSR_RELEASE: begin
          if (gate_i) begin
            state_q <= ADSR_ATTACK;
          end else if (release_diff <= wide_t'(0)) begin
            level_q <= '0;
            state_q <= ADSR_IDLE;
          end else begin
            level_q <= release_diff[env_width_p-1:0];
          end
        end
        default: begin
          state_q <= ADSR_IDLE;
          level_q <= '0;
        end
      endcase
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign state_o = state_q;
  assign level_o = level_q;

endmodule : adsr_envelope

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with default parameters (L = 255).
module tb_adsr_envelope;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               gate_i;
  logic signed [11:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [11:0] data_o;
  logic               valid_o;
  logic               ready_i;
  logic [2:0]         state_o;
  logic [7:0]         level_o;

  int n_checks = 0;
  int n_fail   = 0;

  adsr_envelope dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .gate_i (gate_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .state_o(state_o),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; gate_i = 1'b0; data_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    tick();
    tick();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_o); end
    n_checks++; if (level_o !== 8'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_checks++; if (data_o !== 12'sd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", data_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_attack();
    gate_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 12'sd2047;
    tick();
    n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL attack_enter_state got %0d want 1", state_o); end
    n_checks++; if (level_o !== 8'd0) begin n_fail++; $display("FAIL attack_enter_level got %0d want 0", level_o); end
    n_checks++; if (valid_o !== 1'b1 || data_o !== 12'sd0) begin n_fail++; $display("FAIL attack_first_out got %b/%0d want 1/0", valid_o, data_o); end
    for (int i = 1; i <= 63; i++) begin
      tick();
      n_checks++; if (level_o !== 8'(4 * i)) begin n_fail++; $display("FAIL attack_level i=%0d got %0d want %0d", i, level_o, 4 * i); end
    end
    tick();
    n_checks++; if (level_o !== 8'd255) begin n_fail++; $display("FAIL attack_sat_level got %0d want 255", level_o); end
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL attack_sat_state got %0d want 2", state_o); end
    // 2047*252 >>> 8 = 2015 (multiply uses the pre-step level)
    n_checks++; if (data_o !== 12'sd2015) begin n_fail++; $display("FAIL attack_sat_data got %0d want 2015", data_o); end
  endtask

  task automatic test_scale();
    gate_i = 1'b0; data_i = 12'sd2047;
    tick();
    n_checks++; if (data_o !== 12'sd2039) begin n_fail++; $display("FAIL scale_pos got %0d want 2039", data_o); end
    n_checks++; if (state_o !== 3'd4 || level_o !== 8'd255) begin n_fail++; $display("FAIL scale_rel got %0d/%0d want 4/255", state_o, level_o); end
    gate_i = 1'b1; data_i = -12'sd2048;
    tick();
    n_checks++; if (data_o !== -12'sd2040) begin n_fail++; $display("FAIL scale_neg got %0d want -2040", data_o); end
    n_checks++; if (state_o !== 3'd1 || level_o !== 8'd255) begin n_fail++; $display("FAIL scale_retrig got %0d/%0d want 1/255", state_o, level_o); end
    data_i = 12'sd2047;
    tick();
    n_checks++; if (state_o !== 3'd2 || level_o !== 8'd255) begin n_fail++; $display("FAIL scale_resat got %0d/%0d want 2/255", state_o, level_o); end
  endtask

  task automatic test_decay_sustain();
    for (int i = 1; i <= 63; i++) begin
      tick();
      n_checks++; if (level_o !== 8'(255 - i)) begin n_fail++; $display("FAIL decay_level i=%0d got %0d want %0d", i, level_o, 255 - i); end
      if (i == 62) begin
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL decay_state got %0d want 2", state_o); end
      end
    end
    n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL sustain_enter got %0d want 3", state_o); end
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++; if (level_o !== 8'd192 || state_o !== 3'd3) begin n_fail++; $display("FAIL sustain_hold i=%0d got %0d/%0d want 192/3", i, level_o, state_o); end
    end
  endtask

  task automatic test_release();
    gate_i = 1'b0;
    tick();
    n_checks++; if (state_o !== 3'd4 || level_o !== 8'd192) begin n_fail++; $display("FAIL release_enter got %0d/%0d want 4/192", state_o, level_o); end
    for (int i = 1; i <= 96; i++) begin
      tick();
      n_checks++; if (level_o !== 8'(192 - 2 * i)) begin n_fail++; $display("FAIL release_level i=%0d got %0d want %0d", i, level_o, 192 - 2 * i); end
    end
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL release_idle got %0d want 0", state_o); end
    tick();
    n_checks++; if (data_o !== 12'sd0 || state_o !== 3'd0) begin n_fail++; $display("FAIL idle_data_pos got %0d/%0d want 0/0", data_o, state_o); end
    data_i = -12'sd2048;
    tick();
    n_checks++; if (data_o !== 12'sd0) begin n_fail++; $display("FAIL idle_data_neg got %0d want 0", data_o); end
  endtask

  task automatic test_backpressure();
    gate_i = 1'b1; data_i = 12'sd2047; valid_i = 1'b1; ready_i = 1'b1;
    tick();
    tick();
    tick();
    n_checks++; if (level_o !== 8'd8 || data_o !== 12'sd31) begin n_fail++; $display("FAIL bp_setup got %0d/%0d want 8/31", level_o, data_o); end
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (data_o !== 12'sd31 || ready_o !== 1'b0 || valid_o !== 1'b1 || level_o !== 8'd8) begin
        n_fail++;
        $display("FAIL bp_stall i=%0d got data=%0d rdy=%b vld=%b lvl=%0d want 31/0/1/8", i, data_o, ready_o, valid_o, level_o);
      end
    end
    ready_i = 1'b1;
    tick();
    n_checks++; if (level_o !== 8'd12 || data_o !== 12'sd63) begin n_fail++; $display("FAIL bp_resume got %0d/%0d want 12/63", level_o, data_o); end
    valid_i = 1'b0;
    tick();
    n_checks++; if (valid_o !== 1'b0 || level_o !== 8'd12) begin n_fail++; $display("FAIL bp_drain got %b/%0d want 0/12", valid_o, level_o); end
  endtask

  task automatic test_retrigger();
    int exp_lvl;
    valid_i = 1'b1; gate_i = 1'b1;
    exp_lvl = 12;
    while (exp_lvl < 100) begin
      tick();
      exp_lvl += 4;
      n_checks++; if (level_o !== 8'(exp_lvl)) begin n_fail++; $display("FAIL retrig_up got %0d want %0d", level_o, exp_lvl); end
    end
    gate_i = 1'b0;
    tick();
    n_checks++; if (state_o !== 3'd4 || level_o !== 8'd100) begin n_fail++; $display("FAIL retrig_release got %0d/%0d want 4/100", state_o, level_o); end
    while (exp_lvl > 60) begin
      tick();
      exp_lvl -= 2;
      n_checks++; if (level_o !== 8'(exp_lvl)) begin n_fail++; $display("FAIL retrig_down got %0d want %0d", level_o, exp_lvl); end
    end
    gate_i = 1'b1;
    tick();
    n_checks++; if (state_o !== 3'd1 || level_o !== 8'd60) begin n_fail++; $display("FAIL retrig_attack got %0d/%0d want 1/60", state_o, level_o); end
    tick();
    n_checks++; if (level_o !== 8'd64) begin n_fail++; $display("FAIL retrig_64 got %0d want 64", level_o); end
    tick();
    n_checks++; if (level_o !== 8'd68) begin n_fail++; $display("FAIL retrig_68 got %0d want 68", level_o); end
  endtask

  task automatic test_reset_mid_release();
    gate_i = 1'b0;
    tick();
    tick();
    n_checks++; if (state_o !== 3'd4 || level_o !== 8'd66) begin n_fail++; $display("FAIL mid_rel got %0d/%0d want 4/66", state_o, level_o); end
    ready_i = 1'b0;
    tick();
    n_checks++; if (valid_o !== 1'b1 || level_o !== 8'd66) begin n_fail++; $display("FAIL mid_stall got %b/%0d want 1/66", valid_o, level_o); end
    reset_i = 1'b1;
    tick();
    n_checks++;
    if (state_o !== 3'd0 || level_o !== 8'd0 || valid_o !== 1'b0 || data_o !== 12'sd0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got st=%0d lvl=%0d vld=%b data=%0d rdy=%b want 0/0/0/0/1", state_o, level_o, valid_o, data_o, ready_o);
    end
    reset_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    tick();
    n_checks++; if (valid_o !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL post_reset got %b/%0d want 0/0", valid_o, state_o); end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_scale();
    test_decay_sustain();
    test_release();
    test_backpressure();
    test_retrigger();
    test_reset_mid_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adsr_envelope
